sha256_w_sched: RTL and testbench

SHA256_W_SCHED -- requirements
Module: sha256_w_sched

---
 rtl/sha256_w_sched.sv | 111 +++++++++++
 tb/tb_sha256_w_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_w_sched.sv
// SHA-256 message schedule generator: expands one 512-bit block into W_0..W_63.
// Latency: first word valid the cycle after load_i; one word per accepted transfer; done_o the cycle after W_63 is taken.
// Backpressure: valid/ready handshake; with ready_i low the window, W_o and step_o hold, and valid_o never retracts.
//
// Ports:
//   clk_i, rst_n_i    clock and synchronous active-low reset
//   load_i, block_i   start pulse and 512-bit message block (word 0 in [511:480]); sampled only when idle
//   ready_i           consumer accepts the current W_o/step_o
//   valid_o, W_o      schedule word W_t is presented; W_o reads 0 while idle
//   step_o            round index t, usable directly as the round-constant ROM address
//   busy_o, done_o    block in progress; one-cycle pulse after W_63 is accepted
module sha256_w_sched (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [511:0] block_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [31:0]  W_o,
    output logic [5:0]   step_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_win [16];   // r_win[i] always holds W_(step+i)
    logic [5:0]  r_step;
    logic        r_done;

    logic        w_load;
    logic        w_xfer;
    logic        w_done_nxt;
    logic [31:0] w_new;

    function automatic logic [31:0] f_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Next word entering the window is W_(t+16) = s1(W_(t+14)) + W_(t+9) + s0(W_(t+1)) + W_t.
    assign w_new = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ready_i) begin
                    w_xfer = 1'b1;
                    if (r_step == 6'd63) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_step  <= 6'd0;
            r_done  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                for (int i = 0; i < 16; i++) begin
                    r_win[i] <= block_i[511 - 32*i -: 32];
                end
                r_step <= 6'd0;
            end else if (w_xfer) begin
                for (int i = 0; i < 15; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[15] <= w_new;
                // The transfer at step 63 is also the exit to idle, so the
                // natural 6-bit wrap leaves step at 0 for the idle state.
                r_step <= r_step + 6'd1;
            end
        end
    end

    assign valid_o = (r_state == ST_RUN);
    assign busy_o  = (r_state == ST_RUN);
    assign W_o     = (r_state == ST_RUN) ? r_win[0] : 32'd0;
    assign step_o  = r_step;
    assign done_o  = r_done;

endmodule

// File: tb/tb_sha256_w_sched.sv
module tb_sha256_w_sched;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         load_i;
    logic [511:0] block_i;
    logic         ready_i;
    logic         valid_o;
    logic [31:0]  W_o;
    logic [5:0]   step_o;
    logic         busy_o;
    logic         done_o;

    sha256_w_sched dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (load_i),
        .block_i (block_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .W_o     (W_o),
        .step_o  (step_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [511:0] ABC  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] ZERO = '0;

    typedef struct {
        logic [511:0] blk;
        int           rdy;
        int           step;
        logic [31:0]  exp;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mdl_w [64];
    logic [31:0] got_w [64];
    vec_t        vt [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: FIPS 180-4 schedule expansion over the full 64-entry array.
    task automatic expand(input logic [511:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                mdl_w[t] = blk[511 - 32*t -: 32];
            end else begin
                mdl_w[t] = (rotr(mdl_w[t-2], 17) ^ rotr(mdl_w[t-2], 19) ^ (mdl_w[t-2] >> 10))
                         + mdl_w[t-7]
                         + (rotr(mdl_w[t-15], 7) ^ rotr(mdl_w[t-15], 18) ^ (mdl_w[t-15] >> 3))
                         + mdl_w[t-16];
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        load_i  = 1'b0;
        ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    // Loads one block, drains it with ready asserted rdy_pct percent of the time,
    // optionally pulses load_i with a different block at step inject_step.
    task automatic run_block(input logic [511:0] blk, input int rdy_pct, input int inject_step);
        int          idx;
        int          cyc;
        int          busy_cnt;
        bit          stalled;
        bit          injected;
        logic [31:0] prev_w;
        expand(blk);
        @(negedge clk_i);
        load_i  = 1'b1;
        block_i = blk;
        ready_i = 1'b0;
        @(negedge clk_i);
        load_i   = 1'b0;
        block_i  = rand_block();
        idx      = 0;
        cyc      = 0;
        busy_cnt = 0;
        stalled  = 1'b0;
        injected = 1'b0;
        prev_w   = '0;
        while (idx < 64 && cyc < 3000) begin
            chk("run_valid", valid_o, 1);
            chk("run_busy", busy_o, 1);
            chk("run_done", done_o, 0);
            chk($sformatf("step_%0d", idx), step_o, idx);
            if (stalled) chk("stall_hold_w", W_o, prev_w);
            if (busy_o) busy_cnt++;
            load_i = 1'b0;
            if (idx == inject_step && !injected) begin
                load_i   = 1'b1;
                block_i  = ~blk;
                injected = 1'b1;
            end
            ready_i = ($urandom_range(99) < rdy_pct);
            if (ready_i && valid_o) begin
                chk($sformatf("w_%0d", idx), W_o, mdl_w[idx]);
                got_w[idx] = W_o;
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev_w  = W_o;
            end
            cyc++;
            @(negedge clk_i);
        end
        load_i  = 1'b0;
        ready_i = 1'b0;
        if (idx < 64) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: got %0d transfers expected 64", idx);
            do_reset();
        end else begin
            chk("end_done", done_o, 1);
            chk("end_valid", valid_o, 0);
            chk("end_busy", busy_o, 0);
            chk("end_w", W_o, 0);
            chk("end_step", step_o, 0);
            @(negedge clk_i);
            chk("done_one_cycle", done_o, 0);
            if (rdy_pct >= 100) chk("busy_cycles", busy_cnt, 64);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        load_i  = 1'b0;
        ready_i = 1'b0;
        block_i = '0;
        do_reset();

        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_w", W_o, 0);
        chk("rst_step", step_o, 0);

        // Known-answer vectors
        vt[0] = '{ABC, 100, 0, 32'h61626380};
        vt[1] = '{ABC, 100, 15, 32'h00000018};
        vt[2] = '{ABC, 100, 16, 32'h61626380};
        vt[3] = '{ABC, 100, 17, 32'h000F0000};
        vt[4] = '{ABC, 45, 17, 32'h000F0000};
        vt[5] = '{ZERO, 100, 0, 32'h00000000};
        vt[6] = '{ZERO, 100, 63, 32'h00000000};
        vt[7] = '{ZERO, 60, 40, 32'h00000000};
        for (int i = 0; i < 8; i++) begin
            run_block(vt[i].blk, vt[i].rdy, -1);
            chk($sformatf("vec%0d_w%0d", i, vt[i].step), got_w[vt[i].step], vt[i].exp);
        end

        // load_i during RUN is ignored
        run_block(ABC, 70, 10);
        chk("inject_w16", got_w[16], 32'h61626380);

        // Random blocks, random backpressure
        for (int r = 0; r < 4; r++) begin
            run_block(rand_block(), $urandom_range(90, 30), (r == 1) ? 5 : -1);
        end

        // Reset at step 30 aborts the block; load and ready asserted alongside reset
        begin
            int cyc;
            int n_done;
            int n_valid;
            @(negedge clk_i);
            load_i  = 1'b1;
            block_i = ABC;
            @(negedge clk_i);
            load_i  = 1'b0;
            ready_i = 1'b1;
            cyc = 0;
            while (step_o != 6'd30 && cyc < 200) begin
                @(negedge clk_i);
                cyc++;
            end
            chk("reach_step30", step_o, 30);
            rst_n_i = 1'b0;
            load_i  = 1'b1;
            @(negedge clk_i);
            rst_n_i = 1'b1;
            load_i  = 1'b0;
            chk("abort_valid", valid_o, 0);
            chk("abort_busy", busy_o, 0);
            chk("abort_done", done_o, 0);
            chk("abort_step", step_o, 0);
            chk("abort_w", W_o, 0);
            n_done  = 0;
            n_valid = 0;
            for (int k = 0; k < 80; k++) begin
                @(negedge clk_i);
                if (done_o) n_done++;
                if (valid_o) n_valid++;
            end
            chk("abort_no_done", n_done, 0);
            chk("abort_no_valid", n_valid, 0);
            ready_i = 1'b0;
            run_block(ABC, 100, -1);
        end

        // load_i held high: back-to-back blocks with one idle cycle between
        begin
            logic [511:0] blk;
            int cyc;
            int idx;
            int n_done;
            int n_xfer;
            int last63;
            bit seen63;
            blk = rand_block();
            expand(blk);
            @(negedge clk_i);
            load_i  = 1'b1;
            block_i = blk;
            ready_i = 1'b1;
            cyc = 0; idx = 0; n_done = 0; n_xfer = 0; last63 = 0; seen63 = 1'b0;
            while (n_done < 2 && cyc < 400) begin
                @(negedge clk_i);
                cyc++;
                if (done_o) begin
                    n_done++;
                    chk("b2b_done_time", cyc, last63 + 1);
                    chk("b2b_done_valid", valid_o, 0);
                end
                if (valid_o) begin
                    chk("b2b_step", step_o, idx);
                    chk("b2b_w", W_o, mdl_w[idx]);
                    if (idx == 0 && seen63) chk("b2b_gap", cyc - last63, 2);
                    if (idx == 63) begin
                        last63 = cyc;
                        seen63 = 1'b1;
                    end
                    idx = (idx + 1) % 64;
                    n_xfer++;
                end
            end
            chk("b2b_done_count", n_done, 2);
            chk("b2b_xfers", n_xfer, 128);
            do_reset();
            chk("final_valid", valid_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
